// File: rtl/core_op_feeder.sv
// core_op_feeder: pops host op codes from a small command FIFO and issues them
// to the image core. Load ops stream one image from the memory read port
// through a 2-entry pixel buffer; display ops count the core's result beats.
module core_op_feeder #(
    parameter int unsigned INST_BW   = 4,
    parameter int unsigned INPUT_BW  = 8,
    parameter int unsigned IMG_SIZE  = 2048,
    parameter int unsigned CMD_DEPTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    input  logic [INST_BW-1:0]  i_cmd_op,
    output logic                o_cmd_ready,
    output logic                o_mem_rd,
    output logic [10:0]         o_mem_addr,
    input  logic [INPUT_BW-1:0] i_mem_rdata,
    input  logic                i_op_ready,
    output logic                o_op_valid,
    output logic [INST_BW-1:0]  o_op_mode,
    input  logic                i_in_ready,
    output logic                o_in_valid,
    output logic [INPUT_BW-1:0] o_in_data,
    input  logic                i_out_valid,
    output logic                o_busy,
    output logic                o_err,
    output logic [5:0]          o_depth
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOAD,
        COUNT
    } state_e;

    localparam int unsigned        PW        = $clog2(CMD_DEPTH);
    localparam logic [PW:0]        FIFO_FULL = (PW+1)'(CMD_DEPTH);
    localparam logic [11:0]        IMG_END   = 12'(IMG_SIZE);
    localparam logic [11:0]        IMG_LAST  = 12'(IMG_SIZE - 1);
    localparam logic [INST_BW-1:0] OP_LOAD   = '0;
    localparam logic [INST_BW-1:0] OP_SHRINK = INST_BW'(5);
    localparam logic [INST_BW-1:0] OP_GROW   = INST_BW'(6);
    localparam logic [INST_BW-1:0] OP_DISP_S = INST_BW'(7);
    localparam logic [INST_BW-1:0] OP_DISP_L = INST_BW'(8);
    localparam logic [5:0]         DEPTH_MAX = 6'd32;
    localparam logic [5:0]         DEPTH_MIN = 6'd8;

    // Command FIFO
    logic [INST_BW-1:0]  fifo_q [CMD_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW:0]         fifo_cnt_q, fifo_cnt_d;

    // Sequencer
    state_e              state_q, state_d;
    logic [INST_BW-1:0]  op_q, op_d;
    logic [5:0]          depth_q, depth_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic [8:0]          beat_exp_q, beat_exp_d;
    logic                err_q, err_d;

    // Load prefetch and pixel buffer
    logic [11:0]         rd_addr_q, rd_addr_d;
    logic [11:0]         px_cnt_q, px_cnt_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          buf_cnt_q, buf_cnt_d;
    logic [INPUT_BW-1:0] buf0_q, buf0_d;
    logic [INPUT_BW-1:0] buf1_q, buf1_d;

    logic                push;
    logic                pop;
    logic                consume;
    logic                mem_rd;
    logic                rd_overrun;
    logic [2:0]          outstanding;

    // Handshake decode. Outstanding reads are counted after this cycle's
    // consumption so a read can be launched in the same cycle a pixel leaves,
    // which is what keeps the stream bubble-free with only two buffer slots.
    always_comb begin
        push        = i_cmd_valid && (fifo_cnt_q != FIFO_FULL);
        pop         = (state_q == IDLE) && i_op_ready && (fifo_cnt_q != '0);
        consume     = (state_q == LOAD) && (buf_cnt_q != 2'd0) && i_in_ready;
        outstanding = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, consume};
        mem_rd      = (state_q == LOAD) && (rd_addr_q < IMG_END) && (outstanding < 3'd2);
        rd_overrun  = mem_rd && (outstanding >= 3'd2);
    end

    // Command FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Command FIFO storage; occupancy alone defines emptiness
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= i_cmd_op;
        end
    end

    // Sequencer next state, depth tracking, beat counting and error capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        depth_d    = depth_q;
        beat_cnt_d = beat_cnt_q;
        beat_exp_d = beat_exp_q;
        rd_addr_d  = rd_addr_q;
        px_cnt_d   = px_cnt_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d    = fifo_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rd_addr_d  = '0;
                px_cnt_d   = '0;
                beat_cnt_d = '0;
                if (op_q == OP_LOAD) begin
                    state_d = LOAD;
                    depth_d = DEPTH_MAX;
                end else if (op_q == OP_DISP_S) begin
                    state_d    = COUNT;
                    beat_exp_d = 9'd4;
                end else if (op_q == OP_DISP_L) begin
                    state_d    = COUNT;
                    beat_exp_d = {1'b0, depth_q, 2'b00};
                end else begin
                    state_d = IDLE;
                    if (op_q == OP_SHRINK && depth_q != DEPTH_MIN) begin
                        depth_d = depth_q >> 1;
                    end else if (op_q == OP_GROW && depth_q != DEPTH_MAX) begin
                        depth_d = depth_q << 1;
                    end
                end
            end
            LOAD: begin
                if (mem_rd) begin
                    rd_addr_d = rd_addr_q + 12'd1;
                end
                if (consume) begin
                    if (px_cnt_q == IMG_LAST) begin
                        state_d   = IDLE;
                        rd_addr_d = '0;
                        px_cnt_d  = '0;
                    end else begin
                        px_cnt_d = px_cnt_q + 12'd1;
                    end
                end
            end
            COUNT: begin
                if (i_out_valid) begin
                    if (beat_cnt_q + 9'd1 == beat_exp_q) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((i_op_ready && (state_q == LOAD || state_q == COUNT)) ||
            (i_out_valid && state_q != COUNT) ||
            rd_overrun) begin
            err_d = 1'b1;
        end
    end

    // Pixel buffer: slot 0 is the head, returning read data fills the first
    // free slot after any same-cycle consumption has shifted slot 1 down
    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        buf_cnt_d  = buf_cnt_q;
        inflight_d = mem_rd;
        if (state_q == ISSUE) begin
            buf_cnt_d = '0;
        end
        case ({consume, inflight_q})
            2'b10: begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b01: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_d = i_mem_rdata;
                end else begin
                    buf1_d = i_mem_rdata;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = i_mem_rdata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = i_mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            state_q    <= IDLE;
            op_q       <= '0;
            depth_q    <= DEPTH_MAX;
            beat_cnt_q <= '0;
            beat_exp_q <= '0;
            err_q      <= 1'b0;
            rd_addr_q  <= '0;
            px_cnt_q   <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            state_q    <= state_d;
            op_q       <= op_d;
            depth_q    <= depth_d;
            beat_cnt_q <= beat_cnt_d;
            beat_exp_q <= beat_exp_d;
            err_q      <= err_d;
            rd_addr_q  <= rd_addr_d;
            px_cnt_q   <= px_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    assign o_cmd_ready = (fifo_cnt_q != FIFO_FULL);
    assign o_mem_rd    = mem_rd;
    assign o_mem_addr  = rd_addr_q[10:0];
    assign o_op_valid  = (state_q == ISSUE);
    assign o_op_mode   = (state_q == ISSUE) ? op_q : '0;
    assign o_in_valid  = (state_q == LOAD) && (buf_cnt_q != 2'd0);
    assign o_in_data   = o_in_valid ? buf0_q : '0;
    assign o_busy      = (fifo_cnt_q != '0) || (state_q != IDLE);
    assign o_err       = err_q;
    assign o_depth     = depth_q;

endmodule

// File: tb/tb_core_op_feeder.sv
// tb_core_op_feeder: randomized self-checking bench for core_op_feeder with a
// queue-based command model, arithmetic depth/beat model and a pixel monitor.
module tb_core_op_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [3:0] cmd_op;
    logic       cmd_ready;
    logic       mem_rd;
    logic [10:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       op_ready;
    logic       op_valid;
    logic [3:0] op_mode;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       busy;
    logic       err;
    logic [5:0] depth;

    core_op_feeder #(
        .INST_BW  (4),
        .INPUT_BW (8),
        .IMG_SIZE (2048),
        .CMD_DEPTH(8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cmd_valid(cmd_valid),
        .i_cmd_op   (cmd_op),
        .o_cmd_ready(cmd_ready),
        .o_mem_rd   (mem_rd),
        .o_mem_addr (mem_addr),
        .i_mem_rdata(mem_rdata),
        .i_op_ready (op_ready),
        .o_op_valid (op_valid),
        .o_op_mode  (op_mode),
        .i_in_ready (in_ready),
        .o_in_valid (in_valid),
        .o_in_data  (in_data),
        .i_out_valid(out_valid),
        .o_busy     (busy),
        .o_err      (err),
        .o_depth    (depth)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Image memory: data for address a is a[7:0], one cycle after the read
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? mem_addr[7:0] : 8'($urandom);
    end

    // Pixel stream monitor: order, stall stability, outstanding-read bound
    int   pix_cnt = 0;
    int   loads_done = 0;
    int   rd_total = 0;
    int   cons_total = 0;
    int   max_out = 0;
    int   op_pulses = 0;
    int   mon_out;
    logic mon_cons;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            pix_cnt    = 0;
            rd_total   = 0;
            cons_total = 0;
            stalled    = 1'b0;
        end else begin
            mon_cons = in_valid && in_ready;
            if (stalled) begin
                check_eq("stall_valid", 32'(in_valid), 1);
                check_eq("stall_data", 32'(in_data), 32'(held));
            end
            if (mon_cons) begin
                check_eq("pixel", 32'(in_data), pix_cnt % 256);
                pix_cnt++;
                if (pix_cnt == 2048) begin
                    pix_cnt = 0;
                    loads_done++;
                end
            end
            stalled = in_valid && !in_ready;
            held    = in_data;
            mon_out = rd_total - cons_total + int'(mem_rd) - int'(mon_cons);
            if (mon_out > max_out) max_out = mon_out;
            rd_total   += int'(mem_rd);
            cons_total += int'(mon_cons);
            if (op_valid) op_pulses++;
        end
    end

    // Reference model state
    logic [3:0] model_q[$];
    int         model_depth = 32;

    function automatic int next_depth(input int d, input int op);
        case (op)
            0:       return 32;
            5:       return (d > 8) ? d / 2 : 8;
            6:       return (d < 32) ? d * 2 : 32;
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [3:0] op);
        check_eq("cmd_ready", 32'(cmd_ready), 32'(model_q.size() < 8));
        if (model_q.size() < 8) model_q.push_back(op);
        cmd_op    = op;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic issue_next(output logic [3:0] op);
        bit seen = 0;
        op = (model_q.size() != 0) ? model_q.pop_front() : 4'h0;
        op_ready = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (op_valid) seen = 1;
        end
        op_ready = 1'b0;
        check_eq("issue_seen", 32'(seen), 1);
        check_eq("op_mode", 32'(op_mode), 32'(op));
        model_depth = next_depth(model_depth, int'(op));
        tick();
        check_eq("op_valid_one_cycle", 32'(op_valid), 0);
        check_eq("depth", 32'(depth), model_depth);
    endtask

    // mode 0: ready held high, 1: toggling, 2: random
    task automatic run_load(input int mode);
        int cyc = 0;
        int start = loads_done;
        while (loads_done == start && cyc < 6000) begin
            case (mode)
                0:       in_ready = 1'b1;
                1:       in_ready = (cyc % 2 == 0);
                default: in_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        check_eq("load_done", loads_done - start, 1);
        if (mode == 0) check_eq("load_no_bubbles", 32'(cyc <= 2051), 1);
        check_eq("valid_after_load", 32'(in_valid), 0);
        check_eq("busy_after_load", 32'(busy), 32'(model_q.size() != 0));
        in_ready = 1'b0;
    endtask

    task automatic beat();
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            check_eq("count_busy", 32'(busy), 1);
            beat();
        end
        check_eq("count_done", 32'(busy), 32'(model_q.size() != 0));
    endtask

    task automatic do_op(input int load_mode);
        logic [3:0] op;
        issue_next(op);
        if (op == 4'd0) run_load(load_mode);
        else if (op == 4'd7) run_count(4);
        else if (op == 4'd8) run_count(4 * model_depth);
        else check_eq("idle_path", 32'(busy), 32'(model_q.size() != 0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        check_eq({tag, "_mem_rd"},    32'(mem_rd), 0);
        check_eq({tag, "_op_valid"},  32'(op_valid), 0);
        check_eq({tag, "_in_valid"},  32'(in_valid), 0);
        check_eq({tag, "_busy"},      32'(busy), 0);
        check_eq({tag, "_err"},       32'(err), 0);
        check_eq({tag, "_mem_addr"},  32'(mem_addr), 0);
        check_eq({tag, "_op_mode"},   32'(op_mode), 0);
        check_eq({tag, "_in_data"},   32'(in_data), 0);
        check_eq({tag, "_depth"},     32'(depth), 32);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        model_depth = 32;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int k;
        logic [3:0] op;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0;
        op_ready = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();
        check_reset_outputs("post_por");

        // Plain load with the core always ready
        p0 = op_pulses;
        push_op(4'd0);
        do_op(0);
        check_eq("single_issue_pulse", op_pulses - p0, 1);

        // Load with alternating backpressure
        push_op(4'd0);
        do_op(1);

        // Depth walk, then op 8 at depth 8
        push_op(4'd0); push_op(4'd5); push_op(4'd5); push_op(4'd5); push_op(4'd8);
        for (int i = 0; i < 5; i++) do_op(0);
        check_eq("depth_walk_err", 32'(err), 0);

        // FIFO fill: ninth push refused, issue order preserved
        for (int i = 0; i < 9; i++) begin
            op = (i % 2 == 1) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(9, 15));
            push_op(op);
        end
        check_eq("fifo_full_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 8; i++) do_op(0);
        check_eq("fifo_drained", 32'(busy), 0);

        // Sticky error from op_ready during COUNT
        push_op(4'd7);
        issue_next(op);
        beat(); beat();
        check_eq("err_before", 32'(err), 0);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check_eq("err_set", 32'(err), 1);
        beat(); beat();
        tick(); tick();
        check_eq("err_sticky", 32'(err), 1);
        check_eq("count_finished", 32'(busy), 0);
        apply_reset();
        check_reset_outputs("err_rst");

        // Reset in the middle of a load, then a fresh load from address 0
        push_op(4'd0);
        issue_next(op);
        in_ready = 1'b1;
        k = 0;
        while (pix_cnt < 1000 && k < 1100) begin
            tick();
            k++;
        end
        check_eq("reached_pixel_1000", 32'(pix_cnt >= 1000), 1);
        apply_reset();
        check_reset_outputs("mid_load_rst");
        tick();
        check_eq("no_rd_after_rst", 32'(mem_rd), 0);
        check_eq("no_valid_after_rst", 32'(in_valid), 0);
        in_ready = 1'b0;
        push_op(4'd0);
        do_op(0);

        // Random op mix
        k = 0;
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd0) begin
                if (k >= 2) op = 4'd6;
                else k++;
            end
            push_op(op);
            do_op(2);
        end
        check_eq("random_err", 32'(err), 0);
        check_eq("max_outstanding_le2", 32'(max_out <= 2), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_op_feeder.md
CORE_OP_FEEDER -- requirements
Module: core_op_feeder

Upstream stage that pops 4-bit op codes from a host command FIFO and issues them to the image-processing core. For load ops (mode 0) it streams the 2048-byte image from a memory read port. For display ops (modes 7 and 8) it counts the core's result beats.

Interface
REQ-001 The block SHALL be clocked by a single clock and use a synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning):
- INST_BW, 4: op-code width.
- INPUT_BW, 8: pixel width.
- IMG_SIZE, 2048: bytes per load op (8x8x32).
- CMD_DEPTH, 8: command FIFO entries (power of 2).
REQ-003 Ports (name, direction, width, meaning):
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_cmd_valid, in, 1: host command push request.
- i_cmd_op, in, 4: host op code.
- o_cmd_ready, out, 1: FIFO not full.
- o_mem_rd, out, 1: image memory read enable.
- o_mem_addr, out, 11: image memory read address.
- i_mem_rdata, in, 8: read data, valid exactly 1 cycle after o_mem_rd.
- i_op_ready, in, 1: core accepts an op (level).
- o_op_valid, out, 1: op issue strobe.
- o_op_mode, out, 4: issued op code.
- i_in_ready, in, 1: core accepts the current pixel.
- o_in_valid, out, 1: pixel valid.
- o_in_data, out, 8: pixel byte.
- i_out_valid, in, 1: core result beat.
- o_busy, out, 1: FIFO non-empty or FSM not IDLE.
- o_err, out, 1: sticky protocol-error flag.
- o_depth, out, 6: tracked channel depth (8, 16 or 32).

Function
REQ-004 Command FIFO:
- A push occurs when i_cmd_valid and o_cmd_ready are both high in the same cycle.
- o_cmd_ready SHALL be 0 when the FIFO holds CMD_DEPTH entries.
- A simultaneous push and pop when full SHALL be refused.
- A simultaneous push and pop when not full SHALL keep the count unchanged.
- Read and write pointers SHALL wrap modulo CMD_DEPTH.
REQ-005 FSM states SHALL be IDLE, ISSUE, LOAD and COUNT.
REQ-006 IDLE -> ISSUE when i_op_ready=1 and the FIFO is non-empty; the head entry SHALL be popped on that edge.
REQ-007 In ISSUE, o_op_valid SHALL be 1 and o_op_mode SHALL equal the popped op, for exactly one cycle. The next state SHALL be:
- LOAD if the op is 0.
- COUNT if the op is 7 or 8.
- IDLE otherwise.
REQ-008 Outside ISSUE, o_op_valid SHALL be 0 and o_op_mode SHALL be 0.
REQ-009 LOAD prefetch:
- Addresses 0..IMG_SIZE-1 SHALL be read in order.
- The block SHALL hold a 2-entry pixel buffer.
- o_mem_rd SHALL assert only while (buffered entries + in-flight reads) < 2 and addresses remain.
REQ-010 LOAD streaming:
- o_in_valid SHALL be 1 whenever the buffer is non-empty.
- o_in_data SHALL be the buffer head.
- A pixel SHALL be consumed on each cycle with o_in_valid and i_in_ready both high.
- With i_in_ready held at 1, the first pixel SHALL be presented within 3 cycles of entering LOAD, then one pixel per cycle with no bubbles.
REQ-011 o_in_valid SHALL deassert in the cycle after pixel IMG_SIZE-1 is consumed, and the FSM SHALL then return to IDLE.
REQ-012 Depth tracking:
- Reset and op 0 SHALL set the depth to 32.
- Op 5 SHALL change 32->16 and 16->8; 8 SHALL stay 8.
- Op 6 SHALL change 8->16 and 16->32; 32 SHALL stay 32.
- The depth SHALL update on the ISSUE edge.
REQ-013 COUNT:
- The expected beat count SHALL be 4 for op 7 and 4*depth for op 8.
- A 9-bit counter SHALL increment on each i_out_valid.
- The FSM SHALL move to IDLE on the edge where the count reaches the expected number.
REQ-014 o_err SHALL be set, and SHALL stay set until reset, on any of:
- i_op_ready=1 while in LOAD or COUNT;
- i_out_valid=1 while in IDLE, ISSUE or LOAD;
- a memory read issued while 2 entries are already outstanding (internal assertion).
REQ-015 Op codes above 8 SHALL be issued unchanged and SHALL follow the IDLE path.

Reset
REQ-016 While i_rst=1 at a clock edge, the block SHALL:
- set the FSM to IDLE;
- empty the FIFO and clear both pointers;
- empty the pixel buffer and drop any in-flight read;
- clear the counter;
- set the depth to 32.
REQ-017 During and immediately after reset, the outputs SHALL be:
- o_cmd_ready=1;
- o_mem_rd, o_op_valid, o_in_valid, o_busy and o_err all 0;
- o_mem_addr=0, o_op_mode=0, o_in_data=0;
- o_depth=32.
REQ-018 Reset asserted mid-LOAD or mid-COUNT SHALL abort the operation within the same edge, with no further o_in_valid or o_mem_rd.

Verification
REQ-019 Load: push op 0, hold i_op_ready=1, i_in_ready=1, and memory returns addr[7:0] -> exactly one o_op_valid pulse with mode 0, then 2048 bytes 0x00..0xFF repeating in order, completed within 2060 cycles of the issue.
REQ-020 Backpressure: toggle i_in_ready 1/0 every cycle during a load -> no byte is lost or duplicated, o_in_data stays stable while stalled, and o_mem_rd never has more than 2 reads outstanding.
REQ-021 Depth: push ops 0,5,5,5,8 -> o_depth goes 32,16,8,8, and op 8 completes after exactly 32 i_out_valid beats.
REQ-022 FIFO: push 9 ops with i_op_ready=0 -> o_cmd_ready drops after 8 pushes, the 9th is refused, and the first 8 are issued later in push order.
REQ-023 Errors: assert i_op_ready during COUNT for op 7 after 2 of 4 beats -> o_err=1 and stays 1 until i_rst.
REQ-024 Reset: assert i_rst for 1 cycle at pixel 1000 of a load -> all outputs return to the REQ-017 values on the next cycle, and a fresh op 0 then streams from address 0.
